// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential divider.
package seq_divider_pkg;

    localparam int unsigned DEF_DIVIDEND_W = 36;
    localparam int unsigned DEF_DIVISOR_W  = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// try subtracting the divisor, keep the difference if it did not borrow.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]    i_rem,
    input  logic [DIVIDEND_W-1:0] i_quo,
    input  logic [DIVISOR_W-1:0]  i_div,
    output logic [DIVISOR_W:0]    o_rem,
    output logic [DIVIDEND_W-1:0] o_quo
);

    logic [DIVISOR_W+1:0] w_shift;
    logic [DIVISOR_W+1:0] w_diff;
    logic                 w_ge;

    // Trial subtraction one bit wider than the partial remainder so the borrow is explicit.
    always_comb begin
        w_shift = {i_rem, i_quo[DIVIDEND_W-1]};
        w_diff  = w_shift - {2'b00, i_div};
        w_ge    = ~w_diff[DIVISOR_W+1];
        o_rem   = w_ge ? w_diff[DIVISOR_W:0] : w_shift[DIVISOR_W:0];
        o_quo   = {i_quo[DIVIDEND_W-2:0], w_ge};
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_SIGNED_EN adds the sgn port for two's-complement
// operands (quotient truncated toward zero, remainder takes the dividend sign).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int unsigned DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic                  sgn,
`endif
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_zero
);

    localparam int unsigned     CNT_W    = $clog2(DIVIDEND_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVIDEND_W-1:0] w_quo_nxt;
    logic [DIVISOR_W:0]    r_rem;
    logic [DIVISOR_W:0]    w_rem_nxt;
    logic [DIVISOR_W-1:0]  r_div;
    logic [DIVIDEND_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_zero;
    logic                  r_q_neg;
    logic                  r_r_neg;
    logic                  w_sgn;
    logic                  w_accept;
    logic                  w_zero;
    logic                  w_dvd_neg;
    logic                  w_dsr_neg;
    logic [DIVIDEND_W-1:0] w_dvd_mag;
    logic [DIVISOR_W-1:0]  w_dsr_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
    assign w_sgn = sgn;
`else
    assign w_sgn = 1'b0;
`endif

    // Operand magnitudes and sign bookkeeping taken at acceptance.
    always_comb begin
        w_zero    = (divisor == '0);
        w_dvd_neg = w_sgn & dividend[DIVIDEND_W-1];
        w_dsr_neg = w_sgn & divisor[DIVISOR_W-1];
        w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
        w_dsr_mag = w_dsr_neg ? (~divisor + 1'b1) : divisor;
    end

    div_step #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next-state, acceptance and status outputs.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = w_zero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST_CNT) w_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = w_zero ? DONE : RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Iteration datapath and result registers. RUN spends DIVIDEND_W cycles
    // retiring bits, then one further cycle applies sign correction while
    // loading the result registers on the way into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_div       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
        end else if (w_accept) begin
            r_quo   <= w_dvd_mag;
            r_rem   <= '0;
            r_div   <= w_dsr_mag;
            r_cnt   <= '0;
            r_q_neg <= w_dvd_neg ^ w_dsr_neg;
            r_r_neg <= w_dvd_neg;
            if (w_zero) begin
                r_quotient  <= '1;
                r_remainder <= dividend[DIVISOR_W-1:0];
                r_div_zero  <= 1'b1;
            end
        end else if (r_state == RUN) begin
            if (r_cnt != LAST_CNT) begin
                r_quo <= w_quo_nxt;
                r_rem <= w_rem_nxt;
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_quotient  <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
                r_remainder <= r_r_neg ? (~r_rem[DIVISOR_W-1:0] + 1'b1)
                                       : r_rem[DIVISOR_W-1:0];
                r_div_zero  <= 1'b0;
            end
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with hand-computed expected results.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic        sgn;
`endif
    logic [35:0] dividend;
    logic [17:0] divisor;
    logic        busy;
    logic        done;
    logic [35:0] quotient;
    logic [17:0] remainder;
    logic        div_zero;

    int n_total = 0;
    int n_fail  = 0;

    seq_divider #(
        .DIVIDEND_W (36),
        .DIVISOR_W  (18)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .sgn       (sgn),
`endif
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the cycle after the accepting edge.
    task automatic issue(input logic [35:0] dvd, input logic [17:0] dsr);
        dividend = dvd;
        divisor  = dsr;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Cycles from the current negedge until done is seen; -1 if never.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i <= 60; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    int lat;
    int pulses;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
        sgn      = 1'b0;
`endif
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_quo",  64'(quotient), 64'd0);
        chk("rst_rem",  64'(remainder), 64'd0);
        chk("rst_dz",   64'(div_zero), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 100 / 7
        issue(36'd100, 18'd7);
        chk("b_busy0", 64'(busy), 64'd1);
        wait_done(lat);
        chk("b_lat", 64'(lat), 64'd37);
        chk("b_quo", 64'(quotient), 64'd14);
        chk("b_rem", 64'(remainder), 64'd2);
        chk("b_dz",  64'(div_zero), 64'd0);
        @(negedge clk);
        chk("b_pulse", 64'(done), 64'd0);
        chk("b_hold",  64'(quotient), 64'd14);

        // divide by zero
        issue(36'd5, 18'd0);
        wait_done(lat);
        chk("z_lat", 64'(lat), 64'd0);
        chk("z_quo", 64'(quotient), 64'hF_FFFF_FFFF);
        chk("z_rem", 64'(remainder), 64'd5);
        chk("z_dz",  64'(div_zero), 64'd1);
        @(negedge clk);

        // max dividend / 1
        issue(36'hF_FFFF_FFFF, 18'd1);
        wait_done(lat);
        chk("m_lat", 64'(lat), 64'd37);
        chk("m_quo", 64'(quotient), 64'hF_FFFF_FFFF);
        chk("m_rem", 64'(remainder), 64'd0);
        chk("m_dz",  64'(div_zero), 64'd0);
        @(negedge clk);

        // max divisor
        issue(36'h1_2345_6789, 18'h3FFFF);
        wait_done(lat);
        chk("x_quo", 64'(quotient), 64'd18641);
        chk("x_rem", 64'(remainder), 64'd110682);
        @(negedge clk);
        issue(36'hF_FFFF_FFFF, 18'd1);
        wait_done(lat);
        @(negedge clk);

        // start during RUN is ignored, then back-to-back from DONE
        issue(36'd100, 18'd7);
        repeat (9) @(negedge clk);
        dividend = 36'd50;
        divisor  = 18'd3;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        chk("i_busy", 64'(busy), 64'd1);
        chk("i_done", 64'(done), 64'd0);
        chk("i_hold", 64'(quotient), 64'hF_FFFF_FFFF);
        wait_done(lat);
        chk("i_lat", 64'(lat), 64'd27);
        chk("i_quo", 64'(quotient), 64'd14);
        chk("i_rem", 64'(remainder), 64'd2);
        issue(36'd1000, 18'd10);
        chk("bb_busy", 64'(busy), 64'd1);
        chk("bb_done", 64'(done), 64'd0);
        chk("bb_hold", 64'(quotient), 64'd14);
        wait_done(lat);
        chk("bb_lat", 64'(lat), 64'd37);
        chk("bb_quo", 64'(quotient), 64'd100);
        chk("bb_rem", 64'(remainder), 64'd0);
        @(negedge clk);

        // reset mid-RUN
        issue(36'd100, 18'd7);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("r_busy", 64'(busy), 64'd0);
        chk("r_done", 64'(done), 64'd0);
        chk("r_quo",  64'(quotient), 64'd0);
        chk("r_rem",  64'(remainder), 64'd0);
        chk("r_dz",   64'(div_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("r_pulses", 64'(pulses), 64'd0);
        chk("r_idle",   64'(busy), 64'd0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        // signed -100 / 7
        sgn = 1'b1;
        issue(36'hF_FFFF_FF9C, 18'd7);
        wait_done(lat);
        chk("s_lat", 64'(lat), 64'd37);
        chk("s_quo", 64'(quotient), 64'hF_FFFF_FFF2);
        chk("s_rem", 64'(remainder), 64'h3FFFE);
        sgn = 1'b0;
        @(negedge clk);
`endif

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule
